// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Single-port RAM arbiter for fetch, data and host-loader ports;
//             fixed priority host > data > fetch with a fetch starvation guard.
//  Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int          ADDR_W       = 14,
    parameter logic [31:0] BASE         = 32'h8000_0000,
    parameter int          LATENCY      = 1,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_ack,
    output logic [31:0]       f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [31:0]       h_addr,
    input  logic [31:0]       h_wdata,
    output logic              h_ack,
    output logic [31:0]       h_rdata,
    output logic              m_en,
    output logic [3:0]        m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic              busy,
    output logic              err
);

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam int            LW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [30:0]   DEPTH      = 31'd1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_F = 2'd0,
        SRC_D = 2'd1,
        SRC_H = 2'd2
    } src_t;

    state_t              state_q;
    src_t                src_q;
    logic                we_q;
    logic                rng_q;
    logic [LW-1:0]       lat_q;
    logic [SW-1:0]       starve_q;
    logic                f_ack_q, d_ack_q, h_ack_q, err_q, busy_q, m_en_q;
    logic [3:0]          m_be_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [31:0]         m_wdata_q, f_rdata_q, d_rdata_q, h_rdata_q;

    src_t                src_d;
    logic                we_d, rng_d, any_req_d, done_d;
    logic [3:0]          be_d;
    logic [29:0]         waddr_d, woff_d;
    logic [31:0]         wdata_d;
    logic [SW-1:0]       starve_d;
    logic                unused_addr_lsbs;

    // Byte-offset bits are dropped: the core aligns sub-word accesses itself.
    assign unused_addr_lsbs = ^{f_addr[1:0], d_addr[1:0], h_addr[1:0]};

    always_comb begin
        any_req_d = f_req | d_req | h_req;
        if (f_req && (starve_q == STARVE_MAX || (!h_req && !d_req))) begin
            src_d = SRC_F;
        end else if (h_req) begin
            src_d = SRC_H;
        end else if (d_req) begin
            src_d = SRC_D;
        end else begin
            src_d = SRC_F;
        end

        we_d    = 1'b0;
        be_d    = 4'h0;
        waddr_d = f_addr[31:2];
        wdata_d = 32'h0;
        case (src_d)
            SRC_H: begin
                we_d    = h_we;
                be_d    = h_we ? 4'hF : 4'h0;
                waddr_d = h_addr[31:2];
                wdata_d = h_wdata;
            end
            SRC_D: begin
                we_d    = d_we;
                be_d    = d_we ? d_be : 4'h0;
                waddr_d = d_addr[31:2];
                wdata_d = d_wdata;
            end
            default: ;
        endcase

        // Unsigned word offset: anything below BASE wraps to a huge value.
        woff_d = waddr_d - BASE[31:2];
        rng_d  = ({1'b0, woff_d} < DEPTH);

        if (!f_req || src_d == SRC_F) begin
            starve_d = '0;
        end else if (starve_q == STARVE_MAX) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + SW'(1);
        end

        done_d = (state_q == S_ISSUE && we_q) ||
                 (state_q == S_WAIT && lat_q == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            src_q     <= SRC_F;
            we_q      <= 1'b0;
            rng_q     <= 1'b0;
            lat_q     <= '0;
            starve_q  <= '0;
            f_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            h_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            m_en_q    <= 1'b0;
            m_be_q    <= 4'h0;
            m_addr_q  <= '0;
            m_wdata_q <= 32'h0;
            f_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
            h_rdata_q <= 32'h0;
        end else begin
            f_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            h_ack_q <= 1'b0;
            err_q   <= 1'b0;
            m_en_q  <= 1'b0;
            m_be_q  <= 4'h0;

            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        state_q   <= S_ISSUE;
                        busy_q    <= 1'b1;
                        src_q     <= src_d;
                        we_q      <= we_d;
                        rng_q     <= rng_d;
                        starve_q  <= starve_d;
                        m_en_q    <= rng_d;
                        m_be_q    <= rng_d ? be_d : 4'h0;
                        m_addr_q  <= woff_d[ADDR_W-1:0];
                        m_wdata_q <= wdata_d;
                    end
                end
                S_ISSUE: begin
                    if (we_q) begin
                        state_q <= S_RESP;
                    end else begin
                        state_q <= S_WAIT;
                        lat_q   <= LW'(LATENCY - 1);
                    end
                end
                S_WAIT: begin
                    if (lat_q == '0) begin
                        state_q <= S_RESP;
                    end else begin
                        lat_q <= lat_q - LW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (done_d) begin
                f_ack_q <= (src_q == SRC_F);
                d_ack_q <= (src_q == SRC_D);
                h_ack_q <= (src_q == SRC_H);
                err_q   <= !rng_q;
                if (!we_q) begin
                    case (src_q)
                        SRC_H:   h_rdata_q <= rng_q ? m_rdata : 32'h0;
                        SRC_D:   d_rdata_q <= rng_q ? m_rdata : 32'h0;
                        default: f_rdata_q <= rng_q ? m_rdata : 32'h0;
                    endcase
                end
            end
        end
    end

    assign f_ack   = f_ack_q;
    assign d_ack   = d_ack_q;
    assign h_ack   = h_ack_q;
    assign f_rdata = f_rdata_q;
    assign d_rdata = d_rdata_q;
    assign h_rdata = h_rdata_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign m_en    = m_en_q;
    assign m_be    = m_be_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter (LATENCY 1 and 3).
//  Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int          ADDR_W = 14;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic              f_req = 1'b0;
    logic [31:0]       f_addr = '0;
    logic              f_ack;
    logic [31:0]       f_rdata;
    logic              d_req = 1'b0, d_we = 1'b0;
    logic [3:0]        d_be = '0;
    logic [31:0]       d_addr = '0, d_wdata = '0;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              h_req = 1'b0, h_we = 1'b0;
    logic [31:0]       h_addr = '0, h_wdata = '0;
    logic              h_ack;
    logic [31:0]       h_rdata;
    logic              m_en, busy, err;
    logic [3:0]        m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata, m_rdata;

    logic              g_req = 1'b0;
    logic [31:0]       g_addr = '0;
    logic              g_ack, m_en2, busy2, err2;
    logic [31:0]       g_rdata, m_rdata2;
    logic [ADDR_W-1:0] m_addr2;
    logic [3:0]        m_be2;
    logic [31:0]       m_wdata2;
    logic              unused_d_ack2, unused_h_ack2;
    logic [31:0]       unused_d_rdata2, unused_h_rdata2;

    int n_vec = 0;
    int n_bad = 0;
    int n_men = 0;
    int n_gack = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .BASE(BASE), .LATENCY(1), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_ack(h_ack), .h_rdata(h_rdata),
        .m_en(m_en), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .busy(busy), .err(err)
    );

    mem_arbiter #(.ADDR_W(ADDR_W), .BASE(BASE), .LATENCY(3), .STARVE_LIMIT(4)) u_dut_l3 (
        .clk(clk), .reset_n(reset_n),
        .f_req(g_req), .f_addr(g_addr), .f_ack(g_ack), .f_rdata(g_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_ack(unused_d_ack2), .d_rdata(unused_d_rdata2),
        .h_req(1'b0), .h_we(1'b0), .h_addr(32'h0), .h_wdata(32'h0),
        .h_ack(unused_h_ack2), .h_rdata(unused_h_rdata2),
        .m_en(m_en2), .m_be(m_be2), .m_addr(m_addr2), .m_wdata(m_wdata2), .m_rdata(m_rdata2),
        .busy(busy2), .err(err2)
    );

    // Synchronous 1-cycle RAM behind the main instance.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (m_en) begin
            n_men <= n_men + 1;
            if (m_be == 4'h0) begin
                m_rdata <= mem[m_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
            end
        end
    end

    // 3-cycle read pipe returning an address-derived pattern.
    logic [31:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= m_en2 ? (32'hC0DE_0000 | 32'(m_addr2)) : 32'h0;
        p2 <= p1;
        p3 <= p2;
    end
    assign m_rdata2 = p3;

    always @(negedge clk) if (g_ack) n_gack <= n_gack + 1;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // port: 0 fetch, 1 data, 2 host. lat = negedges from request to ack (-1 on timeout).
    task automatic txn(input int port, input logic we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic e);
        @(negedge clk);
        case (port)
            0: begin f_req = 1'b1; f_addr = a; end
            1: begin d_req = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = wd; end
            default: begin h_req = 1'b1; h_we = we; h_addr = a; h_wdata = wd; end
        endcase
        lat = -1;
        rd  = 32'h0;
        e   = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if ((port == 0 && f_ack) || (port == 1 && d_ack) || (port == 2 && h_ack)) begin
                lat = n;
                rd  = (port == 0) ? f_rdata : (port == 1) ? d_rdata : h_rdata;
                e   = err;
                break;
            end
        end
        f_req = 1'b0;
        d_req = 1'b0;
        h_req = 1'b0;
    endtask

    int          lat, men0, nd, n_f_at, ord, multi;
    logic [31:0] rd;
    logic        e;

    initial begin
        repeat (2) @(negedge clk);
        check_vec("rst_ctrl", {23'h0, f_ack, d_ack, h_ack, err, busy, m_en, m_be}, 32'h0);
        check_vec("rst_addr", 32'(m_addr), 32'h0);
        check_vec("rst_wdata", m_wdata, 32'h0);
        check_vec("rst_rdata", f_rdata | d_rdata | h_rdata, 32'h0);
        reset_n = 1'b1;

        // Program image load through the host port.
        txn(2, 1'b1, 4'h0, 32'h8000_0010, 32'h0000_0013, lat, rd, e);
        check_vec("hw_lat", 32'(lat), 32'd2);
        check_vec("hw_err", 32'(e), 32'h0);
        txn(2, 1'b1, 4'h0, 32'h8000_0020, 32'h1122_3344, lat, rd, e);
        txn(2, 1'b1, 4'h0, 32'h8000_FFFC, 32'hDEAD_BEEF, lat, rd, e);
        check_vec("hw_last_err", 32'(e), 32'h0);

        // Fetch read timing.
        @(negedge clk);
        f_req = 1'b1; f_addr = 32'h8000_0010;
        @(negedge clk);
        check_vec("f_issue", {20'h0, busy, m_en, m_be, 6'(m_addr)}, {20'h0, 1'b1, 1'b1, 4'h0, 6'd4});
        @(negedge clk);
        check_vec("f_ack_early", 32'(f_ack), 32'h0);
        @(negedge clk);
        check_vec("f_ack", {31'h0, f_ack}, 32'h1);
        check_vec("f_rdata", f_rdata, 32'h0000_0013);
        f_req = 1'b0;
        @(negedge clk);
        check_vec("f_idle", {30'h0, busy, f_ack}, 32'h0);

        // Partial data write; payload change after latching is ignored.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h8000_0020; d_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        check_vec("dw_be", {28'h0, m_be}, 32'h3);
        check_vec("dw_addr", 32'(m_addr), 32'd8);
        check_vec("dw_wdata", m_wdata, 32'hAABB_CCDD);
        d_wdata = 32'h0;
        @(negedge clk);
        check_vec("dw_ack", {30'h0, d_ack, err}, 32'h2);
        d_req = 1'b0;
        txn(1, 1'b0, 4'h0, 32'h8000_0022, 32'h0, lat, rd, e);
        check_vec("dr_lat", 32'(lat), 32'd3);
        check_vec("dr_data", rd, 32'h1122_CCDD);
        check_vec("f_hold", f_rdata, 32'h0000_0013);

        // Out-of-range host write: no RAM access, ack+err in write slot.
        men0 = n_men;
        @(negedge clk);
        h_req = 1'b1; h_we = 1'b1; h_addr = 32'h0000_0000; h_wdata = 32'h5555_5555;
        @(negedge clk);
        check_vec("oor_men", {30'h0, busy, m_en}, 32'h2);
        @(negedge clk);
        check_vec("oor_ack", {30'h0, h_ack, err}, 32'h3);
        h_req = 1'b0;
        @(negedge clk);
        check_vec("oor_errpulse", 32'(err), 32'h0);
        check_vec("oor_nomen", 32'(n_men - men0), 32'h0);

        // Address boundaries.
        txn(1, 1'b0, 4'h0, 32'h8000_FFFC, 32'h0, lat, rd, e);
        check_vec("last_rd", rd, 32'hDEAD_BEEF);
        check_vec("last_err", 32'(e), 32'h0);
        txn(2, 1'b0, 4'h0, 32'h8000_0010, 32'h0, lat, rd, e);
        check_vec("h_rd", rd, 32'h0000_0013);
        men0 = n_men;
        txn(2, 1'b0, 4'h0, 32'h8001_0000, 32'h0, lat, rd, e);
        check_vec("beyond_lat", 32'(lat), 32'd3);
        check_vec("beyond_rd", rd, 32'h0);
        check_vec("beyond_err", 32'(e), 32'h1);
        check_vec("beyond_nomen", 32'(n_men - men0), 32'h0);

        // Three simultaneous requests: order host, data, fetch.
        men0 = n_men; ord = 0; multi = 0;
        @(negedge clk);
        h_req = 1'b1; h_we = 1'b0; h_addr = 32'h8000_0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0020;
        f_req = 1'b1; f_addr = 32'h8000_FFFC;
        for (int n = 0; n < 40 && (h_req || d_req || f_req); n++) begin
            @(negedge clk);
            if (int'(h_ack) + int'(d_ack) + int'(f_ack) > 1) multi++;
            if (h_ack) begin ord = ord * 16 + 3; h_req = 1'b0; end
            if (d_ack) begin ord = ord * 16 + 2; d_req = 1'b0; end
            if (f_ack) begin ord = ord * 16 + 1; f_req = 1'b0; end
        end
        h_req = 1'b0; d_req = 1'b0; f_req = 1'b0;
        check_vec("pri_order", 32'(ord), 32'h321);
        check_vec("pri_multi", 32'(multi), 32'h0);
        check_vec("pri_men", 32'(n_men - men0), 32'd3);
        check_vec("pri_data", h_rdata ^ d_rdata ^ f_rdata, 32'h13 ^ 32'h1122_CCDD ^ 32'hDEAD_BEEF);

        // Starvation guard: fetch wins on the fifth arbitration.
        nd = 0; n_f_at = -1;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0020;
        f_req = 1'b1; f_addr = 32'h8000_0010;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (d_ack) nd++;
            if (f_ack) begin n_f_at = nd; break; end
        end
        d_req = 1'b0; f_req = 1'b0;
        check_vec("starve_wins", 32'(n_f_at), 32'd4);
        check_vec("starve_rdata", f_rdata, 32'h0000_0013);

        // Reset during WAIT on the LATENCY=3 instance.
        @(negedge clk);
        g_req = 1'b1; g_addr = 32'h8000_0040;
        @(negedge clk);
        check_vec("l3_issue", {15'h0, m_en2, 16'(m_addr2)}, {15'h0, 1'b1, 16'd16});
        repeat (2) @(negedge clk);
        check_vec("l3_wait", {30'h0, busy2, g_ack}, 32'h2);
        reset_n = 1'b0;
        #1;
        check_vec("l3_rst", {28'h0, busy2, m_en2, g_ack, err2} | 32'(m_addr2), 32'h0);
        repeat (3) @(negedge clk);
        g_addr = 32'h8000_0044;
        reset_n = 1'b1;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (g_ack) begin lat = n; rd = g_rdata; break; end
        end
        g_req = 1'b0;
        check_vec("l3_lat", 32'(lat), 32'd5);
        check_vec("l3_rdata", rd, 32'hC0DE_0011);
        @(negedge clk);
        check_vec("l3_acks", 32'(n_gack), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
